// File: rtl/gpu_pkg.sv
// Shared GPU types and constants: arbiter FSM states, screen defaults, engine ids.
// Coordinate/colour width macros normally come from gpu_definitions.vh; these
// guarded fallbacks keep the package self-contained when it is built alone.
`ifndef WIDTH_BITS
`define WIDTH_BITS 9
`endif
`ifndef HEIGHT_BITS
`define HEIGHT_BITS 8
`endif
`ifndef CHANNEL_BITS
`define CHANNEL_BITS 8
`endif

package gpu_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        SWAP  = 2'd2
    } arb_state_t;

    localparam int SCREEN_W_DEF = 320;
    localparam int SCREEN_H_DEF = 240;

    localparam int REQ_LINE   = 0;
    localparam int REQ_FILL   = 1;
    localparam int REQ_ARC    = 2;
    localparam int REQ_CIRCLE = 3;

endpackage

// File: rtl/gpu_rr_picker.sv
// Combinational round-robin select: first set request at or after ptr, wrapping.
module gpu_rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    // Scan ptr, ptr+1, ... mod NUM_REQ and stop at the first requester.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int j;
            j = int'(ptr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/gpu_pixel_arbiter.sv
// Round-robin arbiter for the framebuffer pixel port with clipping and flush/swap sequencing.
module gpu_pixel_arbiter
    import gpu_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF,
    parameter int CNT_BITS = 16
) (
    input  logic                              clk,
    input  logic                              n_rst,
    input  logic [NUM_REQ-1:0]                req_valid_i,
    input  logic [NUM_REQ*`WIDTH_BITS-1:0]    req_x_i,
    input  logic [NUM_REQ*`HEIGHT_BITS-1:0]   req_y_i,
    output logic [NUM_REQ-1:0]                req_ack_o,
    input  logic [`CHANNEL_BITS-1:0]          r_i,
    input  logic [`CHANNEL_BITS-1:0]          g_i,
    input  logic [`CHANNEL_BITS-1:0]          b_i,
    output logic                              wr_valid_o,
    input  logic                              wr_ready_i,
    output logic [`WIDTH_BITS-1:0]            wr_x_o,
    output logic [`HEIGHT_BITS-1:0]           wr_y_o,
    output logic [`CHANNEL_BITS-1:0]          wr_r_o,
    output logic [`CHANNEL_BITS-1:0]          wr_g_o,
    output logic [`CHANNEL_BITS-1:0]          wr_b_o,
    input  logic                              flush_i,
    output logic                              swap_o,
    input  logic                              swap_ack_i,
    output logic                              flush_done_o,
    output logic                              busy_o,
    output logic [CNT_BITS-1:0]               clip_count_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t           state_q, state_d;
    logic                 swap_d, done_d;
    logic [IDX_W-1:0]     ptr;
    logic [NUM_REQ-1:0]   pick_grant;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_any;
    logic                 slot_free, grant_en, granted, in_range;
    logic [`WIDTH_BITS-1:0]  xs [NUM_REQ];
    logic [`HEIGHT_BITS-1:0] ys [NUM_REQ];
    logic [`WIDTH_BITS-1:0]  sel_x;
    logic [`HEIGHT_BITS-1:0] sel_y;

    // Unpack per-engine coordinates so the winner can be selected by index.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign xs[i] = req_x_i[i*`WIDTH_BITS +: `WIDTH_BITS];
        assign ys[i] = req_y_i[i*`HEIGHT_BITS +: `HEIGHT_BITS];
    end

    gpu_rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_picker (
        .req   (req_valid_i),
        .ptr   (ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // Grant only in RUN with the output slot free; acks are forced low during reset.
    always_comb begin
        slot_free = !wr_valid_o || wr_ready_i;
        grant_en  = n_rst && (state_q == RUN) && slot_free;
        granted   = grant_en && pick_any;
        req_ack_o = grant_en ? pick_grant : '0;
        sel_x     = xs[pick_idx];
        sel_y     = ys[pick_idx];
        in_range  = (int'(sel_x) < SCREEN_W) && (int'(sel_y) < SCREEN_H);
        busy_o    = (state_q != RUN) || wr_valid_o || (|req_valid_i);
    end

    // Output stage: load in-range winners, drop valid once the framebuffer takes it.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            wr_valid_o <= 1'b0;
            wr_x_o     <= '0;
            wr_y_o     <= '0;
            wr_r_o     <= '0;
            wr_g_o     <= '0;
            wr_b_o     <= '0;
        end else if (granted && in_range) begin
            wr_valid_o <= 1'b1;
            wr_x_o     <= sel_x;
            wr_y_o     <= sel_y;
            wr_r_o     <= r_i;
            wr_g_o     <= g_i;
            wr_b_o     <= b_i;
        end else if (wr_ready_i) begin
            wr_valid_o <= 1'b0;
        end
    end

    // Round-robin pointer advances past the winner; saturating clip counter.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            ptr          <= '0;
            clip_count_o <= '0;
        end else if (granted) begin
            ptr <= (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
            if (!in_range && (clip_count_o != '1))
                clip_count_o <= clip_count_o + 1'b1;
        end
    end

    // Flush sequencing: RUN -> DRAIN (stop granting) -> SWAP (wait for ack) -> RUN.
    always_comb begin
        state_d = state_q;
        swap_d  = swap_o;
        done_d  = 1'b0;
        case (state_q)
            RUN:   if (flush_i) state_d = DRAIN;
            DRAIN: if (slot_free) begin
                       state_d = SWAP;
                       swap_d  = 1'b1;
                   end
            SWAP:  if (swap_ack_i) begin
                       state_d = RUN;
                       swap_d  = 1'b0;
                       done_d  = 1'b1;
                   end
            default: state_d = RUN;
        endcase
    end

    // FSM state and its registered outputs.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q      <= RUN;
            swap_o       <= 1'b0;
            flush_done_o <= 1'b0;
        end else begin
            state_q      <= state_d;
            swap_o       <= swap_d;
            flush_done_o <= done_d;
        end
    end

endmodule
